// File: rtl/seg7_scan_counter_if.sv
// seg7_scan_counter_if: control and display bus of the BCD scan counter
// Ports (slave view): en, up_dn, load, load_val in; bcd_out, seg, digit_sel, wrap out
interface seg7_scan_counter_if #(
   parameter int NUM_DIGITS = 3
);
   logic                    en;
   logic                    up_dn;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] load_val;
   logic [4*NUM_DIGITS-1:0] bcd_out;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic                    wrap;
   modport master (output en, up_dn, load, load_val, input bcd_out, seg, digit_sel, wrap);
   modport slave (input en, up_dn, load, load_val, output bcd_out, seg, digit_sel, wrap);
endinterface

// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: N-digit BCD up/down counter with time-multiplexed 7-segment scanner
// Ports: clk, rst (sync, active-high); bus.slave carries en, up_dn, load, load_val
//        in and bcd_out, seg (gfedcba), digit_sel (one-hot), wrap out.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
module seg7_scan_counter #(
   parameter int NUM_DIGITS     = 3,
   parameter int TICK_DIV       = 1000000,
   parameter int SCAN_DIV       = 1000,
   parameter bit SEG_ACTIVE_LOW = 0
) (
   input logic                clk,
   input logic                rst,
   seg7_scan_counter_if.slave bus
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = 4 * NUM_DIGITS;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif
   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0: glyph = 7'h3F;
         4'd1: glyph = 7'h06;
         4'd2: glyph = 7'h5B;
         4'd3: glyph = 7'h4F;
         4'd4: glyph = 7'h66;
         4'd5: glyph = 7'h6D;
         4'd6: glyph = 7'h7D;
         4'd7: glyph = 7'h07;
         4'd8: glyph = 7'h7F;
         default: glyph = 7'h6F;
      endcase
   endfunction
   logic [PW-1:0]         presc_q, presc_d;
   logic [BW-1:0]         bcd_q, bcd_d, bcd_step, bcd_load;
   logic [SW-1:0]         scan_q, scan_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
   logic [6:0]            seg_q, seg_d, seg_raw;
   logic                  wrap_q, wrap_d;
   logic                  tick, scan_tc, all_roll, lz, blank;
   logic [3:0]            cur;
   assign tick    = bus.en && presc_q == PMAX;
   assign scan_tc = scan_q == SMAX;
   // Ripple the step through the digits; all_roll ends high only when every digit rolled over.
   always_comb begin
      bcd_step = bcd_q;
      bcd_load = bus.load_val;
      all_roll = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (all_roll)
            bcd_step[4*i+:4] = bus.up_dn ? (bcd_q[4*i+:4] == 4'd9 ? 4'd0 : bcd_q[4*i+:4] + 4'd1)
                                         : (bcd_q[4*i+:4] == 4'd0 ? 4'd9 : bcd_q[4*i+:4] - 4'd1);
         all_roll = all_roll && (bus.up_dn ? bcd_q[4*i+:4] == 4'd9 : bcd_q[4*i+:4] == 4'd0);
         if (bus.load_val[4*i+:4] > 4'd9)
            bcd_load[4*i+:4] = 4'd9;
      end
   end
   // lz tracks "this digit and all above are zero" while walking down from the top digit.
   always_comb begin
      cur   = 4'd0;
      blank = 1'b0;
      lz    = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz = lz && bcd_q[4*i+:4] == 4'd0;
         if (idx_q == IW'(i)) begin
            cur   = bcd_q[4*i+:4];
            blank = lz && i != 0;
         end
      end
   end
   assign seg_raw = (BLANK_EN && blank) ? 7'h00 : glyph(cur);
   always_comb begin
      presc_d     = bus.load ? '0 : tick ? '0 : bus.en ? presc_q + 1'b1 : presc_q;
      bcd_d       = bus.load ? bcd_load : tick ? bcd_step : bcd_q;
      wrap_d      = !bus.load && tick && all_roll;
      scan_d      = scan_tc ? '0 : scan_q + 1'b1;
      idx_d       = scan_tc ? (idx_q == IMAX ? '0 : idx_q + 1'b1) : idx_q;
      digit_sel_d = NUM_DIGITS'(1) << idx_q;
      seg_d       = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         bcd_q       <= '0;
         scan_q      <= '0;
         idx_q       <= '0;
         digit_sel_q <= NUM_DIGITS'(1);
         seg_q       <= SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
         wrap_q      <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         bcd_q       <= bcd_d;
         scan_q      <= scan_d;
         idx_q       <= idx_d;
         digit_sel_q <= digit_sel_d;
         seg_q       <= seg_d;
         wrap_q      <= wrap_d;
      end
   end
   assign bus.bcd_out   = bcd_q;
   assign bus.seg       = seg_q;
   assign bus.digit_sel = digit_sel_q;
   assign bus.wrap      = wrap_q;
endmodule
